// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: state encoding, default width
// and the bit-counter sizing helper.
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    // One spare bit so the counter never wraps before it reaches WIDTH-1.
    function automatic int cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/Full_Adder_Gate.sv
// Gate-level one-bit full-adder cell used as the serial adder's bit slice.
module Full_Adder_Gate (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    logic prop;
    logic gen;
    logic prop_c;

    assign prop   = a ^ b;
    assign gen    = a & b;
    assign prop_c = prop & cin;
    assign sum    = prop ^ cin;
    assign cout   = gen | prop_c;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: captures a/b/cin, adds one bit per cycle LSB first through
// a single full-adder cell, then holds {cout,sum} until downstream accepts it.
//
// state | meaning
// IDLE  | ready for a new operand set
// SHIFT | one bit added per cycle, WIDTH cycles
// DONE  | result presented, waiting for out_ready
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_t          state;
    state_t          state_nx;
    logic            run_q;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] sum_sr;
    logic            carry_q;
    logic [CW-1:0]   cnt;

    logic            accept;
    logic            last_bit;
    logic            fa_sum;
    logic            fa_cout;

    Full_Adder_Gate u_fa (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .cin  (carry_q),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    // run_q keeps in_ready low on every cycle that follows a reset edge.
    assign in_ready  = run_q && (state == IDLE);
    assign accept    = in_valid && in_ready;
    assign last_bit  = (cnt == LAST_BIT);
    assign out_valid = (state == DONE);
    assign busy      = (state == SHIFT) || (state == DONE);
    assign sum       = sum_sr;
    assign cout      = carry_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            run_q <= 1'b0;
        end else begin
            state <= state_nx;
            run_q <= 1'b1;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nx = SHIFT;
                end
            end
            SHIFT: begin
                if (last_bit) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_sr    <= '0;
            b_sr    <= '0;
            sum_sr  <= '0;
            carry_q <= 1'b0;
            cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_sr    <= a;
                        b_sr    <= b;
                        carry_q <= cin;
                        cnt     <= '0;
                    end
                end
                SHIFT: begin
                    // Sum bits enter at the MSB so bit 0 lands in place after WIDTH shifts.
                    sum_sr  <= {fa_sum, sum_sr[WIDTH-1:1]};
                    a_sr    <= a_sr >> 1;
                    b_sr    <= b_sr >> 1;
                    carry_q <= fa_cout;
                    cnt     <= cnt + CW'(1);
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Directed and random checks of serial_adder at WIDTH=8.
module tb_serial_adder;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         busy;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
    );

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        int           hold;
        logic [W-1:0] exp_sum;
        logic         exp_cout;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Runs one operation starting at a negedge; returns at a negedge with the block idle.
    task automatic do_op(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vc,
                         input int hold, input bit noisy,
                         input logic [W-1:0] exp_sum, input logic exp_cout);
        int lat;
        int waited;
        waited = 0;
        while (!in_ready && waited < 30) begin
            @(negedge clk);
            waited++;
        end
        chk("in_ready_before_op", in_ready, 1);
        a = va; b = vb; cin = vc; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = noisy;
        lat = 0;
        while (!out_valid && lat < 30) begin
            if (noisy) begin
                a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
            end
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        chk("latency", lat, W);
        chk("busy_done", busy, 1);
        chk("in_ready_done", in_ready, 0);
        for (int h = 0; h < hold; h++) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_sum", sum, exp_sum);
            chk("hold_cout", cout, exp_cout);
            @(negedge clk);
        end
        chk("sum", sum, exp_sum);
        chk("cout", cout, exp_cout);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("out_valid_released", out_valid, 0);
        chk("in_ready_after", in_ready, 1);
        chk("busy_after", busy, 0);
    endtask

    logic [W:0] exp_q[$];

    initial begin
        int cycles;
        int sent;
        int got;
        logic [W:0] exp_v;

        vecs[0] = '{8'h0F, 8'h01, 1'b0, 0, 8'h10, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 0, 8'h00, 1'b1};
        vecs[2] = '{8'hFF, 8'hFF, 1'b1, 0, 8'hFF, 1'b1};
        vecs[3] = '{8'h5A, 8'h33, 1'b1, 5, 8'h8E, 1'b0};
        vecs[4] = '{8'h00, 8'h00, 1'b0, 1, 8'h00, 1'b0};
        vecs[5] = '{8'h80, 8'h80, 1'b0, 0, 8'h00, 1'b1};
        vecs[6] = '{8'h00, 8'h00, 1'b1, 2, 8'h01, 1'b0};
        vecs[7] = '{8'hAA, 8'h55, 1'b0, 0, 8'hFF, 1'b0};
        vecs[8] = '{8'h7F, 8'h01, 1'b0, 0, 8'h80, 1'b0};
        vecs[9] = '{8'hFF, 8'h00, 1'b1, 3, 8'h00, 1'b1};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_sum", sum, 0);
        chk("rst_cout", cout, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_in_ready", in_ready, 1);
        chk("rel_out_valid", out_valid, 0);
        chk("rel_busy", busy, 0);
        chk("rel_sum", sum, 0);
        chk("rel_cout", cout, 0);

        for (int i = 0; i < 10; i++) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].hold, 1'b0,
                  vecs[i].exp_sum, vecs[i].exp_cout);
        end

        // New operands offered throughout SHIFT must not disturb the result.
        do_op(8'h12, 8'h34, 1'b0, 2, 1'b1, 8'h46, 1'b0);

        // Reset on the edge after the fourth shift cycle.
        a = 8'h3C; b = 8'h44; cin = 1'b1; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("mid_busy", busy, 1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_sum", sum, 0);
        chk("midrst_cout", cout, 0);
        @(negedge clk);
        chk("midrel_in_ready", in_ready, 1);
        chk("midrel_out_valid", out_valid, 0);
        chk("midrel_busy", busy, 0);
        chk("midrel_sum", sum, 0);
        do_op(8'h01, 8'h01, 1'b0, 0, 1'b0, 8'h02, 1'b0);

        // Random back-to-back traffic with random backpressure.
        sent = 0; got = 0; cycles = 0;
        while ((sent < 1000 || got < sent) && cycles < 40000) begin
            in_valid  = (sent < 1000) ? 1'($urandom_range(0, 3) != 0) : 1'b0;
            a         = W'($urandom);
            b         = W'($urandom);
            cin       = 1'($urandom);
            out_ready = 1'($urandom);
            if (in_valid && in_ready) begin
                exp_q.push_back({1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin});
                sent++;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("rand_spurious_result", 1, 0);
                end else begin
                    exp_v = exp_q.pop_front();
                    chk("rand_result", {cout, sum}, exp_v);
                end
                got++;
            end
            @(negedge clk);
            cycles++;
        end
        in_valid = 1'b0; out_ready = 1'b0;
        chk("rand_sent", sent, 1000);
        chk("rand_got", got, 1000);
        chk("rand_queue_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
